// File: rtl/param_shift_register.sv
// Full-duplex serial shift engine: shifts a DATA_WIDTH-bit word out while capturing one in.
// Optional received-word parity outputs are enabled by defining SHIFT_PARITY_EN.
`timescale 1ns/1ps

module param_shift_register #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 5,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic                  bit_en_i,
   input  logic                  serial_in_i,
   input  logic [DATA_WIDTH-1:0] parallel_in_i,
   input  logic                  data_ack_i,
`ifdef SHIFT_PARITY_EN
   input  logic                  parity_in_i,
   output logic                  parity_out_o,
   output logic                  parity_err_o,
`endif
   output logic                  serial_out_o,
   output logic [DATA_WIDTH-1:0] parallel_out_o,
   output logic                  data_valid_o,
   output logic                  busy_o,
   output logic [CNT_WIDTH-1:0]  bit_count_o
);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shiftReg_q, shiftReg_d;
   logic [DATA_WIDTH-1:0] parallelOut_q, parallelOut_d;
   logic                  serialOut_q, serialOut_d;
   logic                  dataValid_q, dataValid_d;
   logic [CNT_WIDTH-1:0]  bitCount_q, bitCount_d;
`ifdef SHIFT_PARITY_EN
   logic                  parityOut_q, parityOut_d;
   logic                  parityErr_q, parityErr_d;
`endif

   logic [DATA_WIDTH-1:0] shifted;
   logic                  firstBit;
   logic                  nextBit;
   logic                  lastBit;

   // The received bit always enters at the end opposite the transmit end.
   always_comb begin
      if (MSB_FIRST) begin
         shifted  = {shiftReg_q[DATA_WIDTH-2:0], serial_in_i};
         firstBit = parallel_in_i[DATA_WIDTH-1];
         nextBit  = shifted[DATA_WIDTH-1];
      end else begin
         shifted  = {serial_in_i, shiftReg_q[DATA_WIDTH-1:1]};
         firstBit = parallel_in_i[0];
         nextBit  = shifted[0];
      end
      lastBit = (bitCount_q == CNT_WIDTH'(DATA_WIDTH - 1));
   end

   always_comb begin
      state_d       = state_q;
      shiftReg_d    = shiftReg_q;
      parallelOut_d = parallelOut_q;
      serialOut_d   = serialOut_q;
      dataValid_d   = dataValid_q;
      bitCount_d    = bitCount_q;
`ifdef SHIFT_PARITY_EN
      parityOut_d   = parityOut_q;
      parityErr_d   = parityErr_q;
`endif
      if (abort_i) begin
         state_d     = IDLE;
         bitCount_d  = '0;
         serialOut_d = 1'b0;
         dataValid_d = 1'b0;
`ifdef SHIFT_PARITY_EN
         parityOut_d = 1'b0;
         parityErr_d = 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  shiftReg_d  = parallel_in_i;
                  serialOut_d = firstBit;
                  bitCount_d  = '0;
                  state_d     = SHIFT;
               end
            end
            SHIFT: begin
               if (bit_en_i) begin
                  shiftReg_d  = shifted;
                  serialOut_d = nextBit;
                  bitCount_d  = bitCount_q + CNT_WIDTH'(1);
                  if (lastBit) begin
                     parallelOut_d = shifted;
                     dataValid_d   = 1'b1;
                     state_d       = HOLD;
`ifdef SHIFT_PARITY_EN
                     parityOut_d   = ^shifted;
                     parityErr_d   = (^shifted) ^ parity_in_i;
`endif
                  end
               end
            end
            HOLD: begin
               // Ack together with start chains the next frame with no idle gap.
               if (data_ack_i) begin
                  dataValid_d = 1'b0;
                  bitCount_d  = '0;
                  if (start_i) begin
                     shiftReg_d  = parallel_in_i;
                     serialOut_d = firstBit;
                     state_d     = SHIFT;
                  end else begin
                     state_d     = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         shiftReg_q    <= '0;
         parallelOut_q <= '0;
         serialOut_q   <= 1'b0;
         dataValid_q   <= 1'b0;
         bitCount_q    <= '0;
`ifdef SHIFT_PARITY_EN
         parityOut_q   <= 1'b0;
         parityErr_q   <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         shiftReg_q    <= shiftReg_d;
         parallelOut_q <= parallelOut_d;
         serialOut_q   <= serialOut_d;
         dataValid_q   <= dataValid_d;
         bitCount_q    <= bitCount_d;
`ifdef SHIFT_PARITY_EN
         parityOut_q   <= parityOut_d;
         parityErr_q   <= parityErr_d;
`endif
      end
   end

   assign serial_out_o   = serialOut_q;
   assign parallel_out_o = parallelOut_q;
   assign data_valid_o   = dataValid_q;
   assign busy_o         = (state_q == SHIFT) || (state_q == HOLD);
   assign bit_count_o    = bitCount_q;
`ifdef SHIFT_PARITY_EN
   assign parity_out_o   = parityOut_q;
   assign parity_err_o   = parityErr_q;
`endif

endmodule

// File: doc/param_shift_register.md
Name: param_shift_register

Overview:
Parametrised full-duplex serial shift engine for the codec configuration path. One frame of exactly DATA_WIDTH bits is shifted per transaction: a parallel word is shifted out on `serial_out` while `serial_in` is captured into a parallel word. Frames are bounded by a start/ack handshake, and bit timing is paced by an external strobe. The block sits between the config sequencer (parallel side) and the serial bus driver (bit side).

Parameters:
- DATA_WIDTH, 16, frame length in bits; legal range is 2 or more.
- CNT_WIDTH, 5, bit-counter width; must satisfy 2**CNT_WIDTH > DATA_WIDTH.
- MSB_FIRST, 1, bit order:
  - 1 shifts MSB out/in first.
  - 0 shifts LSB first.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  frame request; sampled in IDLE, or in HOLD together with data_ack.
- abort  input  1  synchronous frame cancel.
- bit_en  input  1  bit strobe; one shift per cycle while high in SHIFT.
- serial_in  input  1  received serial bit.
- parallel_in  input  DATA_WIDTH  word to transmit; sampled when start is accepted.
- data_ack  input  1  consumer accepts parallel_out.
- serial_out  output  1  current transmit bit (registered).
- parallel_out  output  DATA_WIDTH  received word (registered).
- data_valid  output  1  parallel_out holds a complete frame.
- busy  output  1  high in SHIFT and HOLD.
- bit_count  output  CNT_WIDTH  bits shifted in the current frame.

Behaviour:
- Reset (async, active-low) sets every output and internal state to zero:
  - state=IDLE, shift reg=0, serial_out=0, parallel_out=0, data_valid=0, busy=0, bit_count=0.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - start=1 and abort=0: shift reg<=parallel_in, bit_count<=0, serial_out<=first bit of parallel_in (MSB if MSB_FIRST=1, else LSB), go to SHIFT.
  - parallel_out and data_valid are unchanged (0 after reset or after an ack).
- SHIFT, on each cycle with bit_en=1:
  - Shift reg shifts one place toward the transmit end; serial_in enters the vacated end.
  - serial_out<=next outgoing bit.
  - bit_count<=bit_count+1.
- SHIFT, cycle with bit_en=0: everything holds.
- End of frame (bit_en=1 while bit_count==DATA_WIDTH-1):
  - parallel_out<=shifted value including this serial_in bit; data_valid<=1; bit_count<=DATA_WIDTH; go to HOLD.
  - Exactly DATA_WIDTH strobes per frame; data_valid rises the cycle after the last strobe.
- HOLD:
  - parallel_out and data_valid hold until data_ack=1; bit_en is ignored.
  - data_ack=1 and start=0: data_valid<=0, bit_count<=0, go to IDLE.
  - data_ack=1 and start=1: back-to-back frame. data_valid<=0, load parallel_in, bit_count<=0, go straight to SHIFT; there is no IDLE cycle.
- start is ignored in SHIFT, and in HOLD without data_ack.
- abort=1 in any state:
  - Next state IDLE, bit_count<=0, serial_out<=0, data_valid<=0.
  - parallel_out keeps its old value.
  - abort has priority over start, bit_en and data_ack in the same cycle.
- data_ack while data_valid=0: no effect.
- Reset asserted mid-frame: immediate return to reset values; no partial word is ever presented.
- bit_count never exceeds DATA_WIDTH and never wraps.

Optional Feature:
- Macro SHIFT_PARITY_EN.
- Defined:
  - Adds output port `parity_out` (1 bit) = XOR reduction of the received word, registered in the same cycle as parallel_out.
  - Also adds input `parity_in` (1 bit), sampled with the last bit_en of the frame.
  - Adds output `parity_err` (1 bit) = parity_out XOR parity_in, valid while data_valid=1.
  - Both outputs reset to 0 and clear on abort.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame:
  - Stimulus: DATA_WIDTH=16, MSB_FIRST=1, parallel_in=16'hA5C3, start pulse, bit_en every cycle, serial_in=16'h1E0F MSB-first.
  - Response: serial_out sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. data_valid rises one cycle after the 16th strobe; parallel_out=16'h1E0F, bit_count=16, busy=1.
- Gapped strobes, LSB-first:
  - Stimulus: MSB_FIRST=0, bit_en high only every 3rd cycle, parallel_in=16'h0001, serial_in=16'h8000 LSB-first.
  - Response: first serial_out bit is 1 and the rest are 0. parallel_out=16'h8000 after exactly 16 strobes, with no shift on idle cycles.
- Back-to-back frames:
  - Stimulus: in HOLD, data_ack and start together with parallel_in=16'h1234.
  - Response: data_valid falls next cycle, state goes to SHIFT with bit_count=0 and no IDLE cycle, first serial_out bit=0.
- Abort mid-frame:
  - Stimulus: abort asserted after 7 strobes, in the same cycle as bit_en.
  - Response: IDLE next cycle, bit_count=0, data_valid stays 0, parallel_out unchanged from the previous frame.
- Hold and reset:
  - Stimulus: in HOLD, 20 cycles of bit_en and start without data_ack; then reset low.
  - Response: parallel_out and data_valid stay stable throughout the 20 cycles. On reset, all outputs go to 0 asynchronously without waiting for a clock edge.
- Parity (SHIFT_PARITY_EN defined):
  - Stimulus: serial word 16'h0007, parity_in=0.
  - Response: parity_out=1 and parity_err=1 while data_valid=1.
